// File: rtl/toothless_lsu_ctrl.sv
// Load/store sequencer: takes one access from execute, runs it over a
// req/gnt/rvalid data bus (split into two word transactions when it crosses a
// word boundary), stalls the core meanwhile and returns extended load data.
module toothless_lsu_ctrl #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_busy_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  typedef enum logic [2:0] {IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  off_q, off_d;
  logic [29:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  m8_q, m8_d;
  logic [31:0] lo_rdata_q, lo_rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  in_mask;
  logic [7:0]  in_m8;
  logic        in_misal;
  logic        in_bad;
  logic [5:0]  rot_sh;
  logic [31:0] in_rot;
  logic [31:0] asm_lo, asm_hi, asm_win, ld_data;

  // Decode the incoming request: byte mask, lane shift, legality, lane-rotated store data
  always_comb begin
    case (lsu_size_i)
      2'b00:   in_mask = 4'b0001;
      2'b01:   in_mask = 4'b0011;
      default: in_mask = 4'b1111;
    endcase
    in_m8    = {4'b0000, in_mask} << lsu_addr_i[1:0];
    in_misal = ((lsu_size_i == 2'b01) && (lsu_addr_i[1:0] == 2'b11)) ||
               ((lsu_size_i == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
    in_bad   = (lsu_size_i == 2'b11) || (in_misal && !SPLIT_MISALIGNED);
    // Rotate left by 8*off, expressed as a right shift of the doubled word
    rot_sh   = 6'd32 - {1'b0, lsu_addr_i[1:0], 3'b000};
    in_rot   = 32'({lsu_wdata_i, lsu_wdata_i} >> rot_sh);
  end

  // Assemble load data from the low word (live or captured) and the high word
  always_comb begin
    asm_lo  = (state_q == WAIT_LO) ? data_rdata_i : lo_rdata_q;
    asm_hi  = (state_q == WAIT_HI) ? data_rdata_i : 32'd0;
    asm_win = 32'({asm_hi, asm_lo} >> {off_q, 3'b000});
    case (size_q)
      2'b00:   ld_data = {{24{sext_q & asm_win[7]}}, asm_win[7:0]};
      2'b01:   ld_data = {{16{sext_q & asm_win[15]}}, asm_win[15:0]};
      default: ld_data = asm_win;
    endcase
  end

  // Next-state logic: accept, request/wait handshakes, completion pulse
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    off_d      = off_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    m8_d       = m8_q;
    lo_rdata_d = lo_rdata_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    rdata_d    = 32'd0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          we_d    = lsu_we_i;
          size_d  = lsu_size_i;
          sext_d  = lsu_sign_ext_i;
          off_d   = lsu_addr_i[1:0];
          waddr_d = lsu_addr_i[31:2];
          wdata_d = in_rot;
          m8_d    = in_m8;
          if (in_bad) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d = REQ_LO;
          end
        end
      end
      REQ_LO: begin
        if (data_gnt_i) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (data_rvalid_i) begin
          lo_rdata_d = data_rdata_i;
          if (!data_err_i && (m8_q[7:4] != 4'b0000)) begin
            state_d = REQ_HI;
          end else begin
            state_d  = IDLE;
            rvalid_d = 1'b1;
            err_d    = data_err_i;
            rdata_d  = (we_q || data_err_i) ? 32'd0 : ld_data;
          end
        end
      end
      REQ_HI: begin
        if (data_gnt_i) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (data_rvalid_i) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = data_err_i;
          rdata_d  = (we_q || data_err_i) ? 32'd0 : ld_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      off_q      <= 2'b00;
      waddr_q    <= 30'd0;
      wdata_q    <= 32'd0;
      m8_q       <= 8'd0;
      lo_rdata_q <= 32'd0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      off_q      <= off_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      m8_q       <= m8_d;
      lo_rdata_q <= lo_rdata_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Bus outputs are driven only while a request is pending, zero otherwise
  always_comb begin
    data_req_o   = (state_q == REQ_LO) || (state_q == REQ_HI);
    data_addr_o  = 32'd0;
    data_be_o    = 4'b0000;
    data_we_o    = data_req_o & we_q;
    data_wdata_o = data_req_o ? wdata_q : 32'd0;
    if (state_q == REQ_LO) begin
      data_addr_o = {waddr_q, 2'b00};
      data_be_o   = m8_q[3:0];
    end else if (state_q == REQ_HI) begin
      data_addr_o = {waddr_q + 30'd1, 2'b00};
      data_be_o   = m8_q[7:4];
    end
  end

  assign lsu_busy_o   = (state_q != IDLE) | lsu_req_i;
  assign lsu_rvalid_o = rvalid_q;
  assign lsu_err_o    = err_q;
  assign lsu_rdata_o  = rdata_q;

endmodule

// File: tb/tb_toothless_lsu_ctrl.sv
// Bench for toothless_lsu_ctrl: directed cases plus randomized accesses checked
// against a byte-level model of which lanes each access touches.
module tb_toothless_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_gnt_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;

  // Second instance without splitting; its bus never answers
  logic        req0;
  logic        busy0, rvalid0, err0, dreq0, dwe0;
  logic [31:0] rdata0, daddr0, dwdata0;
  logic [3:0]  dbe0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  toothless_lsu_ctrl #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  toothless_lsu_ctrl #(.SPLIT_MISALIGNED(1'b0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(req0), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(busy0), .lsu_rvalid_o(rvalid0), .lsu_rdata_o(rdata0),
    .lsu_err_o(err0),
    .data_req_o(dreq0), .data_gnt_i(1'b0), .data_addr_o(daddr0),
    .data_we_o(dwe0), .data_be_o(dbe0), .data_wdata_o(dwdata0),
    .data_rvalid_i(1'b0), .data_rdata_i(32'd0), .data_err_i(1'b0)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One access from accept to the cycle after completion; expectations come
  // from the set of byte addresses the access covers.
  task automatic do_access(input logic we, input logic [1:0] size, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int g_lo, input int r_lo, input logic [31:0] rd_lo, input logic e_lo,
                           input int g_hi, input int r_hi, input logic [31:0] rd_hi, input logic e_hi,
                           output logic [31:0] got_rdata, output logic got_err);
    int off, nb, nph, lane, g, r;
    logic [3:0]  be_exp [2];
    logic [31:0] wa_exp [2];
    logic [31:0] wd_exp, ld_exp, rd;
    logic        err_exp, e;
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_sign_ext_i = sext;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    #1;
    check_val("busy_accept", 32'(lsu_busy_o), 32'd1);
    tick();
    lsu_req_i = 1'b0; lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
    lsu_we_i = 1'($urandom_range(0, 1)); lsu_size_i = 2'($urandom_range(0, 3));
    if (size == 2'b11) begin
      #1;
      check_val("ill_rvalid", 32'(lsu_rvalid_o), 32'd1);
      check_val("ill_err", 32'(lsu_err_o), 32'd1);
      check_val("ill_rdata", lsu_rdata_o, 32'd0);
      check_val("ill_noreq", 32'(data_req_o), 32'd0);
      got_rdata = lsu_rdata_o; got_err = lsu_err_o;
      tick();
      check_val("ill_pulse_end", 32'(lsu_rvalid_o), 32'd0);
      check_val("ill_noreq2", 32'(data_req_o), 32'd0);
      return;
    end
    off = int'(addr[1:0]);
    nb  = 1 << size;
    be_exp[0] = 4'b0000; be_exp[1] = 4'b0000;
    for (int i = 0; i < nb; i++) begin
      if (off + i < 4) be_exp[0][off + i] = 1'b1;
      else             be_exp[1][off + i - 4] = 1'b1;
    end
    wd_exp = 32'd0;
    for (int j = 0; j < 4; j++) wd_exp[8 * ((off + j) % 4) +: 8] = wdata[8 * j +: 8];
    wa_exp[0] = {addr[31:2], 2'b00};
    wa_exp[1] = wa_exp[0] + 32'd4;
    nph = (be_exp[1] != 4'b0000) ? 2 : 1;
    ld_exp = 32'd0;
    for (int i = 0; i < nb; i++) begin
      lane = off + i;
      ld_exp[8 * i +: 8] = (lane < 4) ? rd_lo[8 * lane +: 8] : rd_hi[8 * (lane - 4) +: 8];
    end
    if (sext && ld_exp[8 * nb - 1])
      for (int i = nb; i < 4; i++) ld_exp[8 * i +: 8] = 8'hFF;
    if (we) ld_exp = 32'd0;
    err_exp = e_lo | ((nph == 2) & e_hi);

    for (int p = 0; p < nph; p++) begin
      g  = (p == 0) ? g_lo : g_hi;
      r  = (p == 0) ? r_lo : r_hi;
      rd = (p == 0) ? rd_lo : rd_hi;
      e  = (p == 0) ? e_lo : e_hi;
      for (int k = 0; k <= g; k++) begin
        data_gnt_i = (k == g);
        data_rvalid_i = 1'($urandom_range(0, 1));
        data_rdata_i = $urandom;
        data_err_i = 1'($urandom_range(0, 1));
        #1;
        check_val("req", 32'(data_req_o), 32'd1);
        check_val("addr", data_addr_o, wa_exp[p]);
        check_val("be", 32'(data_be_o), 32'(be_exp[p]));
        check_val("we", 32'(data_we_o), 32'(we));
        check_val("wdata", data_wdata_o, wd_exp);
        check_val("busy_req", 32'(lsu_busy_o), 32'd1);
        check_val("rvalid_early", 32'(lsu_rvalid_o), 32'd0);
        tick();
      end
      data_gnt_i = 1'($urandom_range(0, 1));
      for (int k = 0; k < r; k++) begin
        data_rvalid_i = 1'b0;
        data_err_i = 1'($urandom_range(0, 1));
        #1;
        check_val("req_wait", 32'(data_req_o), 32'd0);
        check_val("rvalid_wait", 32'(lsu_rvalid_o), 32'd0);
        tick();
      end
      data_rvalid_i = 1'b1; data_rdata_i = rd; data_err_i = e;
      tick();
      data_rvalid_i = 1'b0;
      if (e) break;
    end
    data_gnt_i = 1'b0; data_err_i = 1'b0;
    #1;
    check_val("done_rvalid", 32'(lsu_rvalid_o), 32'd1);
    check_val("done_err", 32'(lsu_err_o), 32'(err_exp));
    check_val("done_busy", 32'(lsu_busy_o), 32'd0);
    check_val("done_noreq", 32'(data_req_o), 32'd0);
    if (!err_exp) check_val("done_rdata", lsu_rdata_o, ld_exp);
    got_rdata = lsu_rdata_o; got_err = lsu_err_o;
    data_rvalid_i = 1'($urandom_range(0, 1)); data_rdata_i = $urandom;
    tick();
    check_val("pulse_end", 32'(lsu_rvalid_o), 32'd0);
    check_val("idle_noreq", 32'(data_req_o), 32'd0);
    data_rvalid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rdv;
    logic        errv;
    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00;
    lsu_sign_ext_i = 1'b0; lsu_addr_i = 32'd0; lsu_wdata_i = 32'd0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0; data_err_i = 1'b0;
    req0 = 1'b0;
    repeat (3) tick();
    check_val("rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
    check_val("rst_rdata", lsu_rdata_o, 32'd0);
    check_val("rst_err", 32'(lsu_err_o), 32'd0);
    check_val("rst_req", 32'(data_req_o), 32'd0);
    check_val("rst_addr", data_addr_o, 32'd0);
    check_val("rst_be", 32'(data_be_o), 32'd0);
    check_val("rst_busy", 32'(lsu_busy_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Aligned word load, minimum latency
    do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 0, 0, 32'h0, 1'b0, rdv, errv);
    check_val("t1_rdata", rdv, 32'hDEADBEEF);
    $display("word load 0x100 -> %h err %0d", rdv, errv);
    // Byte load at 0x103 signed and unsigned
    do_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 0, 32'h80112233, 1'b0, 0, 0, 32'h0, 1'b0, rdv, errv);
    check_val("t2_sext", rdv, 32'hFFFFFF80);
    $display("signed byte load 0x103 -> %h", rdv);
    do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1, 2, 32'h80112233, 1'b0, 0, 0, 32'h0, 1'b0, rdv, errv);
    check_val("t2_zext", rdv, 32'h00000080);
    $display("unsigned byte load 0x103 -> %h", rdv);
    // Misaligned word store split in two
    do_access(1'b1, 2'b10, 1'b0, 32'h202, 32'hAABBCCDD, 0, 0, 32'h0, 1'b0, 0, 0, 32'h0, 1'b0, rdv, errv);
    check_val("t3_err", 32'(errv), 32'd0);
    $display("split word store 0x202 err %0d", errv);
    // Misaligned half load, grant held off 3 cycles
    do_access(1'b0, 2'b01, 1'b0, 32'h0FF, 32'h0, 3, 0, 32'h11223344, 1'b0, 1, 1, 32'h55667788, 1'b0, rdv, errv);
    check_val("t4_rdata", rdv, 32'h00008811);
    $display("split half load 0x0FF -> %h", rdv);
    // Bus error on first half of a split
    do_access(1'b0, 2'b10, 1'b0, 32'h201, 32'h0, 0, 1, 32'h12345678, 1'b1, 0, 0, 32'h0, 1'b0, rdv, errv);
    check_val("t5_err", 32'(errv), 32'd1);
    $display("split load with first-half error err %0d", errv);
    // Illegal size
    do_access(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 0, 0, 32'h0, 1'b0, 0, 0, 32'h0, 1'b0, rdv, errv);
    check_val("t6_err", 32'(errv), 32'd1);
    $display("illegal size err %0d", errv);

    // No-split instance: misaligned word flagged without bus access
    lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_addr_i = 32'h1; req0 = 1'b1;
    #1;
    check_val("ns_busy", 32'(busy0), 32'd1);
    tick();
    req0 = 1'b0;
    #1;
    check_val("ns_rvalid", 32'(rvalid0), 32'd1);
    check_val("ns_err", 32'(err0), 32'd1);
    check_val("ns_rdata", rdata0, 32'd0);
    check_val("ns_noreq", 32'(dreq0), 32'd0);
    tick();
    check_val("ns_pulse_end", 32'(rvalid0), 32'd0);
    check_val("ns_noreq2", 32'(dreq0), 32'd0);
    check_val("ns_idle", 32'(busy0), 32'd0);
    $display("no-split misaligned word err %0d", err0);

    // Reset while waiting for the response, then a late response
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_addr_i = 32'h300;
    tick();
    lsu_req_i = 1'b0; data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check_val("rst_mid_req", 32'(data_req_o), 32'd0);
    check_val("rst_mid_busy", 32'(lsu_busy_o), 32'd0);
    data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
    tick();
    data_rvalid_i = 1'b0;
    check_val("rst_mid_norv", 32'(lsu_rvalid_o), 32'd0);
    tick();
    check_val("rst_mid_norv2", 32'(lsu_rvalid_o), 32'd0);
    do_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 0, 32'h0BADBEEF, 1'b0, 0, 0, 32'h0, 1'b0, rdv, errv);
    check_val("t7_rdata", rdv, 32'h0BADBEEF);
    $display("reset mid-access then load 0x300 -> %h", rdv);

    // Randomized accesses
    for (int n = 0; n < 250; n++) begin
      logic        we, sx, el, eh;
      logic [1:0]  sz;
      logic [31:0] ad, wd;
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      sx = 1'($urandom_range(0, 1));
      ad = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
      wd = $urandom;
      el = ($urandom_range(0, 7) == 0);
      eh = ($urandom_range(0, 7) == 0);
      do_access(we, sz, sx, ad, wd,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, el,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, eh, rdv, errv);
      $display("rand %0d: we %0d size %0d addr %h -> rdata %h err %0d", n, we, sz, ad, rdv, errv);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        data_rvalid_i = 1'($urandom_range(0, 1));
        data_gnt_i = 1'($urandom_range(0, 1));
        tick();
        check_val("gap_norv", 32'(lsu_rvalid_o), 32'd0);
        check_val("gap_noreq", 32'(data_req_o), 32'd0);
      end
      data_rvalid_i = 1'b0; data_gnt_i = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
